// File: rtl/game_pkg.sv
// Shared definitions for the symbol-counting game: FSM states, period
// one-hot codes and the default period durations.
package game_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_PRE    = 3'd1,
      ST_GAME   = 3'd2,
      ST_ANSWER = 3'd3,
      ST_POST   = 3'd4,
      ST_JUDGE  = 3'd5,
      ST_OVER   = 3'd6
   } state_t;

   // One-hot period codes, bit order {pre, game, answer, post}
   localparam logic [3:0] PERIOD_NONE   = 4'b0000;
   localparam logic [3:0] PERIOD_PRE    = 4'b1000;
   localparam logic [3:0] PERIOD_GAME   = 4'b0100;
   localparam logic [3:0] PERIOD_ANSWER = 4'b0010;
   localparam logic [3:0] PERIOD_POST   = 4'b0001;

   // Default durations in seconds, also used by the period display modules
   localparam int DEF_PRELIM_SEC    = 3;
   localparam int DEF_GAME_SEC_BASE = 10;
   localparam int DEF_GAME_SEC_MIN  = 3;
   localparam int DEF_ANSWER_SEC    = 5;
   localparam int DEF_POST_SEC      = 2;
   localparam int DEF_MAX_LEVEL     = 9;
   localparam int DEF_SEC_W         = 5;

   // Map a state to the period level that should be shown while in it
   function automatic logic [3:0] period_onehot(input state_t s);
      logic [3:0] p;
      p = PERIOD_NONE;
      case (s)
         ST_PRE:    p = PERIOD_PRE;
         ST_GAME:   p = PERIOD_GAME;
         ST_ANSWER: p = PERIOD_ANSWER;
         ST_POST:   p = PERIOD_POST;
         default:   p = PERIOD_NONE;
      endcase
      return p;
   endfunction

endpackage

// File: rtl/sec_countdown.sv
// Loadable seconds down-counter. A load takes priority over a coincident
// tick, so the tick that triggers a reload is consumed by the reload.
module sec_countdown #(
   parameter int SEC_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             load,
   input  logic [SEC_W-1:0] load_val,
   input  logic             tick,
   output logic [SEC_W-1:0] value,
   output logic             expire
);

   logic [SEC_W-1:0] value_q;
   logic [SEC_W-1:0] value_d;

   // Next count: load wins, otherwise decrement on tick while non-zero
   always_comb begin
      value_d = value_q;
      if (load) begin
         value_d = load_val;
      end else if (tick && (value_q != '0)) begin
         value_d = value_q - SEC_W'(1);
      end
   end

   // Count register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value  = value_q;
   assign expire = tick && (value_q == SEC_W'(1));

endmodule

// File: rtl/period_sequencer.sv
// Game-flow controller: walks PRE -> GAME -> ANSWER -> POST -> JUDGE,
// times each period from the 1 Hz strobe and applies the judge verdict.
module period_sequencer
   import game_pkg::*;
#(
   parameter int PRELIM_SEC    = DEF_PRELIM_SEC,
   parameter int GAME_SEC_BASE = DEF_GAME_SEC_BASE,
   parameter int GAME_SEC_MIN  = DEF_GAME_SEC_MIN,
   parameter int ANSWER_SEC    = DEF_ANSWER_SEC,
   parameter int POST_SEC      = DEF_POST_SEC,
   parameter int MAX_LEVEL     = DEF_MAX_LEVEL,
   parameter int SEC_W         = DEF_SEC_W
) (
   input  logic             Clk100M,
   input  logic             resetN,
   input  logic             tick1Hz,
   input  logic             startReq,
   input  logic             judgeValid,
   input  logic             judgePass,
   output logic             prelimSig,
   output logic             gameSig,
   output logic             answerSig,
   output logic             postSig,
   output logic             pre,
   output logic             game,
   output logic             answer,
   output logic             post,
   output logic             startGen,
   output logic             stopGen,
   output logic             stopCount,
   output logic             levelComplete,
   output logic [SEC_W-1:0] secLeft,
   output logic [3:0]       curLevel,
   output logic             win,
   output logic             lose
);

   localparam int SEC_MAX = (1 << SEC_W) - 1;
   localparam int WIDE_W  = SEC_W + 4;

   // Reject durations that do not fit the seconds counter
   if (PRELIM_SEC < 1 || PRELIM_SEC > SEC_MAX ||
       GAME_SEC_BASE < 1 || GAME_SEC_BASE > SEC_MAX ||
       GAME_SEC_MIN < 1 || GAME_SEC_MIN > SEC_MAX ||
       ANSWER_SEC < 1 || ANSWER_SEC > SEC_MAX ||
       POST_SEC < 1 || POST_SEC > SEC_MAX) begin : g_bad_len
      $error("period_sequencer: period length out of range for SEC_W");
   end
   if (MAX_LEVEL < 1 || MAX_LEVEL > 15) begin : g_bad_level
      $error("period_sequencer: MAX_LEVEL must be 1..15");
   end

   state_t           state_q, state_d;
   logic [3:0]       period_q, period_d;
   logic [7:0]       pulse_q, pulse_d;
   logic [3:0]       level_q, level_d;
   logic             win_q, win_d;
   logic             lose_q, lose_d;

   logic             cnt_load;
   logic [SEC_W-1:0] cnt_load_val;
   logic             cnt_tick;
   logic             cnt_expire;
   logic [SEC_W-1:0] cnt_value;

   logic [WIDE_W-1:0] lvl_m1;
   logic [WIDE_W-1:0] game_wide;
   logic [SEC_W-1:0]  game_len;

   // Pulse vector bit positions
   localparam int B_PRELIM = 7;
   localparam int B_GAME   = 6;
   localparam int B_ANSWER = 5;
   localparam int B_POST   = 4;
   localparam int B_START  = 3;
   localparam int B_STOPG  = 2;
   localparam int B_STOPC  = 1;
   localparam int B_LVLC   = 0;

   // Ticks only count inside the timed periods
   assign cnt_tick = tick1Hz && ((state_q == ST_PRE) || (state_q == ST_GAME) ||
                                 (state_q == ST_ANSWER) || (state_q == ST_POST));

   sec_countdown #(
      .SEC_W (SEC_W)
   ) u_countdown (
      .clk      (Clk100M),
      .rst_n    (resetN),
      .load     (cnt_load),
      .load_val (cnt_load_val),
      .tick     (cnt_tick),
      .value    (cnt_value),
      .expire   (cnt_expire)
   );

   // Game length shrinks one second per level, clamped at the minimum;
   // compared in the wide domain so the subtraction never wraps
   always_comb begin
      lvl_m1 = WIDE_W'(level_q) - WIDE_W'(1);
      if ((lvl_m1 + WIDE_W'(GAME_SEC_MIN)) >= WIDE_W'(GAME_SEC_BASE)) begin
         game_wide = WIDE_W'(GAME_SEC_MIN);
      end else begin
         game_wide = WIDE_W'(GAME_SEC_BASE) - lvl_m1;
      end
      game_len = SEC_W'(game_wide);
   end

   // Next-state, counter load and output computation
   always_comb begin
      state_d      = state_q;
      pulse_d      = '0;
      level_d      = level_q;
      win_d        = win_q;
      lose_d       = lose_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      case (state_q)
         ST_IDLE, ST_OVER: begin
            if (startReq) begin
               state_d           = ST_PRE;
               level_d           = 4'd1;
               win_d             = 1'b0;
               lose_d            = 1'b0;
               cnt_load          = 1'b1;
               cnt_load_val      = SEC_W'(PRELIM_SEC);
               pulse_d[B_PRELIM] = 1'b1;
            end
         end
         ST_PRE: begin
            if (cnt_expire) begin
               state_d          = ST_GAME;
               cnt_load         = 1'b1;
               cnt_load_val     = game_len;
               pulse_d[B_GAME]  = 1'b1;
               pulse_d[B_START] = 1'b1;
            end
         end
         ST_GAME: begin
            if (cnt_expire) begin
               state_d           = ST_ANSWER;
               cnt_load          = 1'b1;
               cnt_load_val      = SEC_W'(ANSWER_SEC);
               pulse_d[B_ANSWER] = 1'b1;
               pulse_d[B_STOPG]  = 1'b1;
            end
         end
         ST_ANSWER: begin
            if (cnt_expire) begin
               state_d          = ST_POST;
               cnt_load         = 1'b1;
               cnt_load_val     = SEC_W'(POST_SEC);
               pulse_d[B_POST]  = 1'b1;
               pulse_d[B_STOPC] = 1'b1;
            end
         end
         ST_POST: begin
            if (cnt_expire) begin
               state_d         = ST_JUDGE;
               cnt_load        = 1'b1;
               cnt_load_val    = '0;
               pulse_d[B_LVLC] = 1'b1;
            end
         end
         ST_JUDGE: begin
            if (judgeValid) begin
               if (judgePass && (level_q < 4'(MAX_LEVEL))) begin
                  state_d           = ST_PRE;
                  level_d           = level_q + 4'd1;
                  cnt_load          = 1'b1;
                  cnt_load_val      = SEC_W'(PRELIM_SEC);
                  pulse_d[B_PRELIM] = 1'b1;
               end else if (judgePass) begin
                  state_d = ST_OVER;
                  win_d   = 1'b1;
               end else begin
                  state_d = ST_OVER;
                  lose_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      period_d = period_onehot(state_d);
   end

   // State and registered outputs
   always_ff @(posedge Clk100M or negedge resetN) begin
      if (!resetN) begin
         state_q  <= ST_IDLE;
         period_q <= PERIOD_NONE;
         pulse_q  <= '0;
         level_q  <= '0;
         win_q    <= 1'b0;
         lose_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         period_q <= period_d;
         pulse_q  <= pulse_d;
         level_q  <= level_d;
         win_q    <= win_d;
         lose_q   <= lose_d;
      end
   end

   assign prelimSig     = pulse_q[B_PRELIM];
   assign gameSig       = pulse_q[B_GAME];
   assign answerSig     = pulse_q[B_ANSWER];
   assign postSig       = pulse_q[B_POST];
   assign startGen      = pulse_q[B_START];
   assign stopGen       = pulse_q[B_STOPG];
   assign stopCount     = pulse_q[B_STOPC];
   assign levelComplete = pulse_q[B_LVLC];
   assign pre           = period_q[3];
   assign game          = period_q[2];
   assign answer        = period_q[1];
   assign post          = period_q[0];
   assign secLeft       = cnt_value;
   assign curLevel      = level_q;
   assign win           = win_q;
   assign lose          = lose_q;

endmodule

// File: doc/period_sequencer.md
# period_sequencer

Central game-flow controller for the symbol-counting game. It steps the design through preliminary, game, answer and post periods, and counts each period's length in seconds from a 1 Hz strobe. It issues the one-cycle start/stop pulses that drive the symbol generator, user counter and scorer, then applies the judge's verdict to advance the level, declare a win or declare a loss. It sits beside the period display modules and replaces ad-hoc period chaining with one FSM.

## Interface
- PRELIM_SEC, 3: preliminary period length, in seconds
- GAME_SEC_BASE, 10: game period length at level 1
- GAME_SEC_MIN, 3: floor on game period length
- ANSWER_SEC, 5: answer period length
- POST_SEC, 2: post period length
- MAX_LEVEL, 9: final level; passing it wins
- SEC_W, 5: width of the seconds counter
- Clk100M  in  1  system clock (the only clock)
- resetN  in  1  asynchronous, active-low reset
- tick1Hz  in  1  one-cycle strobe, once per second, synchronous to Clk100M
- startReq  in  1  one-cycle user start pulse
- judgeValid  in  1  one-cycle pulse: verdict available
- judgePass  in  1  verdict; sampled only with judgeValid
- prelimSig, gameSig, answerSig, postSig  out  1  one-cycle pulse on entry to each period
- pre, game, answer, post  out  1  one-hot "current period" levels; all 0 in IDLE, JUDGE and OVER
- startGen  out  1  pulse, same cycle as gameSig
- stopGen  out  1  pulse, same cycle as answerSig
- stopCount  out  1  pulse, same cycle as postSig
- levelComplete  out  1  pulse when the post period expires
- secLeft  out  SEC_W  seconds remaining in the current period
- curLevel  out  4  current level; 0 in IDLE, 1..MAX_LEVEL otherwise
- win, lose  out  1  sticky result flags

## Operation
- States: IDLE, PRE, GAME, ANSWER, POST, JUDGE, OVER.
- Start (from IDLE or OVER):
  - startReq moves to PRE.
  - curLevel := 1, win := 0, lose := 0, secLeft := PRELIM_SEC, prelimSig pulses.
- Timed states (PRE, GAME, ANSWER, POST):
  - On a tick with secLeft > 1: decrement secLeft.
  - On a tick with secLeft == 1: expire, load the next period's length and pulse its signals.
- Transitions on expiry:
  - PRE to GAME: secLeft := max(GAME_SEC_BASE − (curLevel−1), GAME_SEC_MIN); gameSig and startGen pulse.
  - GAME to ANSWER: secLeft := ANSWER_SEC; answerSig and stopGen pulse.
  - ANSWER to POST: secLeft := POST_SEC; postSig and stopCount pulse.
  - POST to JUDGE: secLeft := 0; levelComplete pulses.
- JUDGE: waits, untimed, for judgeValid.
  - Pass with curLevel < MAX_LEVEL: curLevel+1, go to PRE, reload PRELIM_SEC, prelimSig pulses.
  - Pass with curLevel == MAX_LEVEL: go to OVER, win := 1.
  - Fail: go to OVER, lose := 1.
- OVER: holds win, lose, curLevel and secLeft until startReq.
- Ignored inputs:
  - startReq outside IDLE/OVER is ignored.
  - judgeValid outside JUDGE is ignored.
  - tick1Hz in IDLE, JUDGE and OVER is ignored.
- Width rules:
  - All parameter lengths are 1..2^SEC_W−1; an elaboration-time check rejects any other value.
  - Game-length arithmetic is done at SEC_W+4 bits before clamping, so no underflow.

## Timing
- All outputs are registered. Reset values: state IDLE, every pulse and every level 0, secLeft 0, curLevel 0, win 0, lose 0.
- Pulses are high for exactly the one cycle after the edge that samples the triggering input. Period levels change on that same edge.
- The load cycle consumes a coincident tick: a tick arriving with startReq, or on the expiry tick itself, does not also decrement. A period of N seconds therefore ends on the N-th tick after entry.
- Simultaneous inputs:
  - startReq together with tick1Hz in IDLE: enter PRE with the full PRELIM_SEC.
  - judgeValid together with tick1Hz: the verdict wins.
- resetN low at any point returns immediately to IDLE with reset values. Pulses in flight are dropped; no stop pulse is emitted.

## Structure
- Shared package game_pkg holds:
  - the state enum;
  - the period one-hot constants;
  - the default durations and MAX_LEVEL, which the period display modules reuse.
- One sub-module, sec_countdown: a loadable SEC_W down-counter with tick enable.
  - Outputs: expire (tick with value == 1) and value.
  - The FSM owns its load and load value.

## Test plan
- Start at level 1 with default parameters:
  - startReq, then 3 ticks: gameSig and startGen pulse together, secLeft = 10.
  - 10 more ticks: answerSig and stopGen pulse.
  - 5 more ticks: postSig and stopCount pulse.
  - 2 more ticks: levelComplete pulses.
- Pass at level 1: judgeValid=1 with judgePass=1 gives curLevel = 2 and a prelimSig pulse. The next game period has secLeft = 9.
- Clamp and win:
  - Pass repeatedly; from level 8 onward the game period length is 3.
  - A pass at level 9 gives win = 1 and OVER; all period levels are 0.
- Fail: judgePass=0 gives lose = 1 and OVER. A later startReq clears lose and sets curLevel = 1.
- Coincident and ignored inputs:
  - A tick in the same cycle as startReq gives secLeft = 3, not 2.
  - startReq during GAME changes nothing.
  - judgeValid during ANSWER changes nothing.
- Reset mid-period: resetN low during GAME with secLeft = 4 immediately gives IDLE, all outputs 0, and no stopGen pulse.
